// File: rtl/fe_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
package fe_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_ILEN_BYTES = 4;

    typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_e;
    typedef enum logic [1:0] {SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_SEQ} pc_sel_e;

endpackage

// File: rtl/fe_next_pc_mux.sv
// Priority select of the next fetch PC: trap > redirect > stall > sequential.
module fe_next_pc_mux
    import fe_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned ILEN_BYTES = DEF_ILEN_BYTES
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            enable,
    input  logic            accept,
    input  logic [XLEN-1:0] pc_q,
    output pc_sel_e         sel_c,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misaligned_c
);

    localparam int unsigned ALIGN_W = $clog2(ILEN_BYTES);

    always_comb begin
        sel_c        = SEL_SEQ;
        next_pc_c    = pc_q;
        misaligned_c = 1'b0;
        if (trap_valid) begin
            sel_c     = SEL_TRAP;
            next_pc_c = trap_pc;
        end else if (redirect_valid) begin
            sel_c = SEL_REDIR;
            // A misaligned target is diverted straight to the trap handler.
            if (redirect_pc[ALIGN_W-1:0] != '0) begin
                misaligned_c = 1'b1;
                next_pc_c    = trap_pc;
            end else begin
                next_pc_c = redirect_pc;
            end
        end else if (!enable) begin
            sel_c = SEL_HOLD;
        end else if (accept) begin
            next_pc_c = pc_q + XLEN'(ILEN_BYTES);
        end
    end

endmodule

// File: rtl/fe_pc_gen.sv
// Fetch PC generator: holds pc_q, runs the boot/run/halt state machine,
// issues imem requests and registers the fetched PC towards IF/ID.
module fe_pc_gen
    import fe_pkg::*;
#(
    parameter int unsigned     XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ILEN_BYTES   = DEF_ILEN_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic [XLEN-1:0] fe_pc_out,
    output logic            fe_valid,
    output logic            misaligned,
    output logic            halted
);

    pc_state_e       state;
    logic [XLEN-1:0] pc_q;
    logic            accept;
    pc_sel_e         sel_c;
    logic [XLEN-1:0] next_pc_c;
    logic            misaligned_c;

    assign imem_req  = (state == PC_RUN) && enable;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    fe_next_pc_mux #(
        .XLEN       (XLEN),
        .ILEN_BYTES (ILEN_BYTES)
    ) u_mux (
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .enable         (enable),
        .accept         (accept),
        .pc_q           (pc_q),
        .sel_c          (sel_c),
        .next_pc_c      (next_pc_c),
        .misaligned_c   (misaligned_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PC_BOOT;
            pc_q       <= RESET_VECTOR;
            fe_pc_out  <= '0;
            fe_valid   <= 1'b0;
            misaligned <= 1'b0;
            halted     <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                PC_BOOT: begin
                    state <= PC_RUN;
                end
                PC_RUN, PC_HALT: begin
                    pc_q       <= next_pc_c;
                    misaligned <= misaligned_c;
                    case (sel_c)
                        SEL_TRAP, SEL_REDIR: fe_valid <= 1'b0;
                        SEL_HOLD:            ;
                        SEL_SEQ: begin
                            if (accept) begin
                                fe_pc_out <= pc_q;
                                fe_valid  <= 1'b1;
                            end else begin
                                fe_valid <= 1'b0;
                            end
                        end
                        default:             fe_valid <= 1'b0;
                    endcase
                    if (state == PC_RUN) begin
                        if (halt_req && !trap_valid && !redirect_valid) begin
                            state  <= PC_HALT;
                            halted <= 1'b1;
                        end
                    end else begin
                        // Nothing is fetched while halted, even under a stall.
                        fe_valid <= 1'b0;
                        if (resume_req) begin
                            state  <= PC_RUN;
                            halted <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= PC_BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe_pc_gen.sv
// Directed bench for fe_pc_gen: expected fetch PCs are queued by the stimulus
// and popped by an independent monitor whenever a new fetch is presented.
module tb_fe_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        halt_req;
    logic        resume_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] fe_pc_out;
    logic        fe_valid;
    logic        misaligned;
    logic        halted;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        en_q = 1'b0;

    fe_pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .fe_pc_out      (fe_pc_out),
        .fe_valid       (fe_valid),
        .misaligned     (misaligned),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A valid output is a new fetch only if the preceding edge was not a stall.
    always @(posedge clk) en_q <= enable && !rst;

    always @(negedge clk) begin
        if (fe_valid && en_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", fe_pc_out, 32'hxxxx_xxxx);
            end else begin
                chk("fetch_pc", fe_pc_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; imem_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        trap_valid = 1'b0; trap_pc = '0;
        halt_req = 1'b0; resume_req = 1'b0;
        step(); step();
        chk("rst_fe_valid", 32'(fe_valid), 32'd0);
        chk("rst_fe_pc", fe_pc_out, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        #1;
        chk("boot_no_req", 32'(imem_req), 32'd0);
        step();
        chk("run_req", 32'(imem_req), 32'd1);

        // Sequential fetch 0, 4
        exp_q.push_back(32'h0); step();
        exp_q.push_back(32'h4); step();
        chk("addr_at_8", imem_addr, 32'h8);

        // Memory not ready for 3 cycles at 0x8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_valid", 32'(fe_valid), 32'd0);
        end
        imem_ready = 1'b1;
        exp_q.push_back(32'h8);  step();
        exp_q.push_back(32'hC);  step();
        exp_q.push_back(32'h10); step();

        // Stall two cycles; redirect arrives during the second
        enable = 1'b0;
        #1;
        chk("stall_no_req", 32'(imem_req), 32'd0);
        step();
        chk("stall_pc_hold", fe_pc_out, 32'h10);
        chk("stall_valid_hold", 32'(fe_valid), 32'd1);
        chk("stall_addr_hold", imem_addr, 32'h14);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("stall_redir_addr", imem_addr, 32'h100);
        chk("stall_redir_valid", 32'(fe_valid), 32'd0);
        redirect_valid = 1'b0; enable = 1'b1;
        exp_q.push_back(32'h100); step();

        // Trap and redirect together: trap wins
        trap_valid = 1'b1; trap_pc = 32'h200;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("trap_addr", imem_addr, 32'h200);
        chk("trap_valid_clr", 32'(fe_valid), 32'd0);
        trap_valid = 1'b0; redirect_valid = 1'b0;
        exp_q.push_back(32'h200); step();

        // Misaligned redirect goes to trap_pc
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        chk("misaligned_set", 32'(misaligned), 32'd1);
        chk("misaligned_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        exp_q.push_back(32'h200); step();
        chk("misaligned_pulse", 32'(misaligned), 32'd0);

        // Wrap from 0xFFFF_FFFC
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC); step();
        chk("wrap_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0); step();

        // Halt, then resume with halt_req still asserted
        chk("run_not_halted", 32'(halted), 32'd0);
        halt_req = 1'b1;
        exp_q.push_back(32'h4); step();
        halt_req = 1'b0;
        chk("halted_set", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        step();
        chk("halt_valid", 32'(fe_valid), 32'd0);
        chk("halt_addr", imem_addr, 32'h8);
        halt_req = 1'b1; resume_req = 1'b1;
        step();
        chk("resume_wins", 32'(halted), 32'd0);
        halt_req = 1'b0; resume_req = 1'b0;
        exp_q.push_back(32'h8); step();
        exp_q.push_back(32'hC); step();

        imem_ready = 1'b0;
        step(); step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
